// File: rtl/spi_slave_sync.sv
// SPI mode-0 register-access slave, fully clocked by the system clock.
// Frame: 1 R/W bit (1 = read), ADDRW address bits, DATAW data bits, MSB first.
// SCLK/SS/MOSI pass through 2-FF synchronisers; SCLK edges come from a third FF.
// Optional feature macro: SPI_AUTOINC_EN (burst mode with address auto-increment).
`timescale 1ns/1ps

module spi_slave_sync #(
    parameter int ADDRW = 4,
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             spien,
    input  logic             spiclk,
    input  logic             spidin,
    output logic             spidout,
    output logic             spioe,
    output logic             rdt,
    output logic             wrt,
    output logic             rdreq,
    input  logic [DATAW-1:0] rddata,
    output logic             wrstb,
    output logic [ADDRW-1:0] addr,
    output logic [DATAW-1:0] wrtdata
);

    localparam int MAXW = (ADDRW > DATAW) ? ADDRW : DATAW;
    localparam int CNTW = $clog2(MAXW + 1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
`ifdef SPI_AUTOINC_EN
    localparam logic [ADDRW-1:0] ADDR_ONE = ADDRW'(1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Shift one serial bit into the LSB of an address word.
    function automatic logic [ADDRW-1:0] addr_shift(input logic [ADDRW-1:0] v, input logic b);
        return (v << 1'b1) | ADDRW'(b);
    endfunction

    // Shift one serial bit into the LSB of a data word.
    function automatic logic [DATAW-1:0] data_shift(input logic [DATAW-1:0] v, input logic b);
        return (v << 1'b1) | DATAW'(b);
    endfunction

    logic             en_meta_r, en_sync_r;
    logic             sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic             din_meta_r, din_sync_r;
    logic [1:0]       valid_r;
    logic             armed_r;

    state_t           state_r, state_n;
    logic [CNTW-1:0]  cnt_r, cnt_n;
    logic             mode_r, mode_n;
    logic [ADDRW-1:0] addr_r, addr_n;
    logic [DATAW-1:0] wrtdata_r, wrtdata_n;
    logic [DATAW-1:0] miso_r, miso_n;
    logic             rdt_r, rdt_n;
    logic             wrt_r, wrt_n;
    logic             rdreq_r, rdreq_n;
    logic             wrstb_r, wrstb_n;
    logic             spioe_r, spioe_n;

    logic             sclk_rise_s, sclk_fall_s, frame_start_s;

    // Synchronise the asynchronous pins and track when a fresh slave-select rise is allowed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_meta_r   <= 1'b0;
            en_sync_r   <= 1'b0;
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            din_meta_r  <= 1'b0;
            din_sync_r  <= 1'b0;
            valid_r     <= 2'b00;
            armed_r     <= 1'b0;
        end else begin
            en_meta_r   <= spien;
            en_sync_r   <= en_meta_r;
            sclk_meta_r <= spiclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            din_meta_r  <= spidin;
            din_sync_r  <= din_meta_r;
            // The reset value of the synchroniser is not a real "low" on the pin, so a
            // slave select already high when reset releases must not start a frame.
            valid_r     <= {valid_r[0], 1'b1};
            armed_r     <= valid_r[1] & ~en_sync_r;
        end
    end

    assign sclk_rise_s   = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall_s   = ~sclk_sync_r & sclk_prev_r;
    assign frame_start_s = en_sync_r & armed_r;

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        mode_n    = mode_r;
        addr_n    = addr_r;
        wrtdata_n = wrtdata_r;
        miso_n    = miso_r;
        rdt_n     = rdt_r;
        wrt_n     = wrt_r;
        rdreq_n   = 1'b0;
        wrstb_n   = 1'b0;
        spioe_n   = 1'b0;

`ifdef SPI_AUTOINC_EN
        // Write burst: the address moves on only after the strobe used the old value.
        if (wrstb_r) begin
            addr_n = addr_r + ADDR_ONE;
        end else begin
            addr_n = addr_r;
        end
`endif

        // MISO: load the read word the clk after rdreq; never shift before the first
        // data rise of a word so the master samples the MSB on that rise.
        if (rdreq_r) begin
            miso_n = rddata;
        end else if (sclk_fall_s && (state_r == ST_DATA) && (cnt_r != CNT_ZERO)) begin
            miso_n = {miso_r[DATAW-2:0], 1'b0};
        end else begin
            miso_n = miso_r;
        end

        if (!en_sync_r) begin
            // Deselect aborts everything; addr/wrtdata keep their last values.
            state_n = ST_IDLE;
            cnt_n   = CNT_ZERO;
            mode_n  = 1'b0;
            addr_n  = addr_r;
            miso_n  = {DATAW{1'b0}};
            rdt_n   = 1'b0;
            wrt_n   = 1'b0;
            rdreq_n = 1'b0;
            wrstb_n = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_start_s) begin
                        state_n = ST_CMD;
                        cnt_n   = CNT_ZERO;
                        mode_n  = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        mode_n  = din_sync_r;
                        state_n = ST_ADDR;
                        cnt_n   = CNT_ZERO;
                    end else begin
                        state_n = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        addr_n = addr_shift(addr_r, din_sync_r);
                        if (cnt_r == CNTW'(ADDRW - 1)) begin
                            state_n = ST_DATA;
                            cnt_n   = CNT_ZERO;
                            rdt_n   = mode_r;
                            wrt_n   = ~mode_r;
                            rdreq_n = mode_r;
                        end else begin
                            cnt_n = cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                ST_DATA: begin
                    if (sclk_rise_s) begin
                        if (!mode_r) begin
                            wrtdata_n = data_shift(wrtdata_r, din_sync_r);
                        end else begin
                            wrtdata_n = wrtdata_r;
                        end
                        if (cnt_r == CNTW'(DATAW - 1)) begin
                            cnt_n   = CNT_ZERO;
                            wrstb_n = ~mode_r;
`ifdef SPI_AUTOINC_EN
                            state_n = ST_DATA;
                            if (mode_r) begin
                                addr_n  = addr_r + ADDR_ONE;
                                rdreq_n = 1'b1;
                            end else begin
                                rdreq_n = 1'b0;
                            end
`else
                            state_n = ST_DONE;
`endif
                        end else begin
                            cnt_n = cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_n = ST_DATA;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = CNT_ZERO;
                end
            endcase
        end

        spioe_n = en_sync_r & mode_n &
                  ((state_n == ST_ADDR) || (state_n == ST_DATA) || (state_n == ST_DONE));
    end

    // Frame state and all output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            mode_r    <= 1'b0;
            addr_r    <= {ADDRW{1'b0}};
            wrtdata_r <= {DATAW{1'b0}};
            miso_r    <= {DATAW{1'b0}};
            rdt_r     <= 1'b0;
            wrt_r     <= 1'b0;
            rdreq_r   <= 1'b0;
            wrstb_r   <= 1'b0;
            spioe_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            mode_r    <= mode_n;
            addr_r    <= addr_n;
            wrtdata_r <= wrtdata_n;
            miso_r    <= miso_n;
            rdt_r     <= rdt_n;
            wrt_r     <= wrt_n;
            rdreq_r   <= rdreq_n;
            wrstb_r   <= wrstb_n;
            spioe_r   <= spioe_n;
        end
    end

    assign spidout = miso_r[DATAW-1];
    assign spioe   = spioe_r;
    assign rdt     = rdt_r;
    assign wrt     = wrt_r;
    assign rdreq   = rdreq_r;
    assign wrstb   = wrstb_r;
    assign addr    = addr_r;
    assign wrtdata = wrtdata_r;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: two instances (4/8 and 7/16 widths).
// Stimulus tasks push expected strobes/MISO bits; monitors pop and compare.
`timescale 1ns/1ps

module tb_spi_slave_sync;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    // Instance A: ADDRW=4, DATAW=8
    logic       a_en, a_sclk, a_din, a_dout, a_oe, a_rdt, a_wrt, a_rdreq, a_wrstb;
    logic [7:0] a_rddata, a_wdata;
    logic [3:0] a_addr;
    logic [7:0] a_mem [16];

    // Instance B: ADDRW=7, DATAW=16
    logic        b_en, b_sclk, b_din, b_dout, b_oe, b_rdt, b_wrt, b_rdreq, b_wrstb;
    logic [15:0] b_rddata, b_wdata;
    logic [6:0]  b_addr;

    assign a_rddata = a_mem[a_addr];
    assign b_rddata = 16'h0000;

    spi_slave_sync #(.ADDRW(4), .DATAW(8)) u_dut_a (
        .clk(clk), .rstn(rstn), .spien(a_en), .spiclk(a_sclk), .spidin(a_din),
        .spidout(a_dout), .spioe(a_oe), .rdt(a_rdt), .wrt(a_wrt), .rdreq(a_rdreq),
        .rddata(a_rddata), .wrstb(a_wrstb), .addr(a_addr), .wrtdata(a_wdata)
    );

    spi_slave_sync #(.ADDRW(7), .DATAW(16)) u_dut_b (
        .clk(clk), .rstn(rstn), .spien(b_en), .spiclk(b_sclk), .spidin(b_din),
        .spidout(b_dout), .spioe(b_oe), .rdt(b_rdt), .wrt(b_wrt), .rdreq(b_rdreq),
        .rddata(b_rddata), .wrstb(b_wrstb), .addr(b_addr), .wrtdata(b_wdata)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] a_wr_q   [$];
    logic [3:0]  a_rd_q   [$];
    logic        a_miso_q [$];
    logic        a_oe_q   [$];
    logic [22:0] b_wr_q   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_a_wr();
        logic [11:0] e;
        if (a_wr_q.size() == 0) begin
            check("a_wrstb_spurious", {31'd0, a_wrstb}, 32'd0);
        end else begin
            e = a_wr_q.pop_front();
            check("a_wr_addr", {28'd0, a_addr}, {28'd0, e[11:8]});
            check("a_wr_data", {24'd0, a_wdata}, {24'd0, e[7:0]});
        end
    endtask

    task automatic mon_a_rd();
        logic [3:0] e;
        if (a_rd_q.size() == 0) begin
            check("a_rdreq_spurious", {31'd0, a_rdreq}, 32'd0);
        end else begin
            e = a_rd_q.pop_front();
            check("a_rd_addr", {28'd0, a_addr}, {28'd0, e});
        end
    endtask

    task automatic mon_b_wr();
        logic [22:0] e;
        if (b_wr_q.size() == 0) begin
            check("b_wrstb_spurious", {31'd0, b_wrstb}, 32'd0);
        end else begin
            e = b_wr_q.pop_front();
            check("b_wr_addr", {25'd0, b_addr}, {25'd0, e[22:16]});
            check("b_wr_data", {16'd0, b_wdata}, {16'd0, e[15:0]});
        end
    endtask

    task automatic mon_a_pin();
        logic e;
        if (a_oe_q.size() != 0) begin
            e = a_oe_q.pop_front();
            check("a_spioe", {31'd0, a_oe}, {31'd0, e});
        end
        if (a_rdt) begin
            if (a_miso_q.size() == 0) begin
                check("a_miso_extra", {31'd0, a_rdt}, 32'd0);
            end else begin
                e = a_miso_q.pop_front();
                check("a_miso_bit", {31'd0, a_dout}, {31'd0, e});
            end
        end
    endtask

    // Strobe monitors sampled on the falling clk edge
    always @(negedge clk) begin
        if (a_wrstb) mon_a_wr();
        if (a_rdreq) mon_a_rd();
        if (b_wrstb) mon_b_wr();
        if (b_rdreq) check("b_rdreq_spurious", {31'd0, b_rdreq}, 32'd0);
    end

    // Pin-level monitor: the master samples MISO/OE on each SCLK rise
    always @(posedge a_sclk) mon_a_pin();

    // Drive n bits MSB first; pos0 is the frame position of the first bit (0 = R/W bit)
    task automatic spi_bits(input int which, input int n, input logic [63:0] bits,
                            input logic oe_mode, input int pos0);
        for (int i = n - 1; i >= 0; i--) begin
            if (which == 0) a_din = bits[i]; else b_din = bits[i];
            repeat (8) @(negedge clk);
            if (which == 0) a_oe_q.push_back(oe_mode && ((pos0 + (n - 1 - i)) > 0));
            if (which == 0) a_sclk = 1'b1; else b_sclk = 1'b1;
            repeat (8) @(negedge clk);
            if (which == 0) a_sclk = 1'b0; else b_sclk = 1'b0;
        end
    endtask

    task automatic frame_start(input int which);
        if (which == 0) a_en = 1'b1; else b_en = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end(input int which);
        repeat (8) @(negedge clk);
        if (which == 0) a_en = 1'b0; else b_en = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic push_miso(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) a_miso_q.push_back(v[i]);
    endtask

    task automatic check_a_all_zero(input string tag);
        check({tag, "_dout"},  {31'd0, a_dout},  32'd0);
        check({tag, "_oe"},    {31'd0, a_oe},    32'd0);
        check({tag, "_rdt"},   {31'd0, a_rdt},   32'd0);
        check({tag, "_wrt"},   {31'd0, a_wrt},   32'd0);
        check({tag, "_rdreq"}, {31'd0, a_rdreq}, 32'd0);
        check({tag, "_wrstb"}, {31'd0, a_wrstb}, 32'd0);
        check({tag, "_addr"},  {28'd0, a_addr},  32'd0);
        check({tag, "_wdata"}, {24'd0, a_wdata}, 32'd0);
    endtask

    initial begin
        a_en = 1'b0; a_sclk = 1'b0; a_din = 1'b0;
        b_en = 1'b0; b_sclk = 1'b0; b_din = 1'b0;
        for (int i = 0; i < 16; i++) a_mem[i] = 8'h00;
        a_mem[3]  = 8'h3C;
        a_mem[6]  = 8'h96;
        a_mem[14] = 8'hC3;
        a_mem[15] = 8'h5A;
        a_mem[0]  = 8'h81;
        rstn = 1'b1;
        #3 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_a_all_zero("reset");
        check("reset_b_wrstb", {31'd0, b_wrstb}, 32'd0);
        check("reset_b_wdata", {16'd0, b_wdata}, 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0xA5 to address 5
        a_wr_q.push_back({4'h5, 8'hA5});
        frame_start(0);
        spi_bits(0, 13, {51'd0, 1'b0, 4'h5, 8'hA5}, 1'b0, 0);
        check("wr_wrt_level", {31'd0, a_wrt}, 32'd1);
        check("wr_rdt_level", {31'd0, a_rdt}, 32'd0);
        frame_end(0);
        check("wr_wrt_after", {31'd0, a_wrt}, 32'd0);

        // Read address 3 (0x3C)
        a_rd_q.push_back(4'h3);
`ifdef SPI_AUTOINC_EN
        a_rd_q.push_back(4'h4);
`endif
        push_miso(8'h3C, 8);
        frame_start(0);
        spi_bits(0, 13, {51'd0, 1'b1, 4'h3, 8'h00}, 1'b1, 0);
        check("rd_rdt_level", {31'd0, a_rdt}, 32'd1);
        check("rd_oe_level",  {31'd0, a_oe},  32'd1);
        frame_end(0);
        check("rd_oe_after",   {31'd0, a_oe},   32'd0);
        check("rd_rdt_after",  {31'd0, a_rdt},  32'd0);
        check("rd_dout_after", {31'd0, a_dout}, 32'd0);

        // Abort a write after 4 data bits, then a full write
        frame_start(0);
        spi_bits(0, 9, {55'd0, 1'b0, 4'h5, 4'hA}, 1'b0, 0);
        check("abort_wrt_before", {31'd0, a_wrt}, 32'd1);
        a_en = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_rdt",  {31'd0, a_rdt},  32'd0);
        check("abort_wrt",  {31'd0, a_wrt},  32'd0);
        check("abort_oe",   {31'd0, a_oe},   32'd0);
        check("abort_addr", {28'd0, a_addr}, 32'd5);
        repeat (8) @(negedge clk);
        a_wr_q.push_back({4'h9, 8'h3C});
        frame_start(0);
        spi_bits(0, 13, {51'd0, 1'b0, 4'h9, 8'h3C}, 1'b0, 0);
        frame_end(0);

        // Reset in the middle of a read of address 6 (0x96)
        a_rd_q.push_back(4'h6);
        push_miso(8'h96, 3);
        frame_start(0);
        spi_bits(0, 8, {56'd0, 1'b1, 4'h6, 3'b000}, 1'b1, 0);
        #2 rstn = 1'b0;
        #1 check_a_all_zero("midrst");
        @(negedge clk);
        rstn = 1'b1;
        spi_bits(0, 4, {60'd0, 4'hA}, 1'b0, 1);
        check("midrst_rdt_after", {31'd0, a_rdt}, 32'd0);
        check("midrst_oe_after",  {31'd0, a_oe},  32'd0);
        frame_end(0);
        a_rd_q.push_back(4'h6);
`ifdef SPI_AUTOINC_EN
        a_rd_q.push_back(4'h7);
`endif
        push_miso(8'h96, 8);
        frame_start(0);
        spi_bits(0, 13, {51'd0, 1'b1, 4'h6, 8'h00}, 1'b1, 0);
        frame_end(0);

        // Wide instance: write 0x5A3C to address 0x41, then extra clocks
        b_wr_q.push_back({7'h41, 16'h5A3C});
        frame_start(1);
        spi_bits(1, 24, {40'd0, 1'b0, 7'h41, 16'h5A3C}, 1'b0, 0);
        check("b_wrt_level", {31'd0, b_wrt}, 32'd1);
        spi_bits(1, 4, {60'd0, 4'hF}, 1'b0, 24);
        check("b_oe_level",   {31'd0, b_oe},   32'd0);
        check("b_rdt_level",  {31'd0, b_rdt},  32'd0);
        check("b_dout_level", {31'd0, b_dout}, 32'd0);
        frame_end(1);

`ifdef SPI_AUTOINC_EN
        // Read burst of three words starting at 0xE, wrapping to 0x0
        a_rd_q.push_back(4'hE);
        a_rd_q.push_back(4'hF);
        a_rd_q.push_back(4'h0);
        a_rd_q.push_back(4'h1);
        push_miso(8'hC3, 8);
        push_miso(8'h5A, 8);
        push_miso(8'h81, 8);
        frame_start(0);
        spi_bits(0, 29, {35'd0, 1'b1, 4'hE, 24'h000000}, 1'b1, 0);
        frame_end(0);
`endif

        repeat (20) @(negedge clk);
        check("a_wr_q_left",   a_wr_q.size(),   32'd0);
        check("a_rd_q_left",   a_rd_q.size(),   32'd0);
        check("a_miso_q_left", a_miso_q.size(), 32'd0);
        check("b_wr_q_left",   b_wr_q.size(),   32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
